// File: rtl/audio_pdm_pkg.sv
// audio_pdm_pkg
// Shared definitions for the PDM audio DAC slice: sample and mixer widths,
// volume range, the offset-binary midpoint, the volume FSM state type and
// the mixer sign-extension / saturation helpers.
// No ports (package).
package audio_pdm_pkg;

    localparam int SAMPLE_W = 16;
    localparam int MIX_W    = 24;
    localparam int VOL_W    = 9;
    localparam int VOL_MAX  = 256;

    localparam logic [SAMPLE_W-1:0] LEVEL_MID = 16'h8000;

    localparam logic signed [MIX_W-1:0] MIX_POS_LIM = 24'sd32767;
    localparam logic signed [MIX_W-1:0] MIX_NEG_LIM = -24'sd32768;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } vol_state_t;

    function automatic logic signed [MIX_W-1:0] sext_sample(input logic signed [SAMPLE_W-1:0] s);
        return {{(MIX_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    function automatic logic mix_clipped(input logic signed [MIX_W-1:0] v);
        return (v > MIX_POS_LIM) || (v < MIX_NEG_LIM);
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [MIX_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > MIX_POS_LIM) begin
            r = 16'sh7FFF;
        end else if (v < MIX_NEG_LIM) begin
            r = 16'sh8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_pdm_dac_if.sv
// audio_pdm_dac_if
// Bundles the DAC's sample/control inputs and audio/status outputs.
//   master: drives opl_sample, tandy_sample, sample_toggle, speaker, mute_req;
//           observes aud_l, aud_r, level, clip, ramp_busy.
//   slave : the DAC side, the opposite directions.
interface audio_pdm_dac_if;
    import audio_pdm_pkg::*;

    logic [SAMPLE_W-1:0] opl_sample;
    logic [SAMPLE_W-1:0] tandy_sample;
    logic                sample_toggle;
    logic                speaker;
    logic                mute_req;
    logic                aud_l;
    logic                aud_r;
    logic [SAMPLE_W-1:0] level;
    logic                clip;
    logic                ramp_busy;

    modport master (
        output opl_sample, tandy_sample, sample_toggle, speaker, mute_req,
        input  aud_l, aud_r, level, clip, ramp_busy
    );

    modport slave (
        input  opl_sample, tandy_sample, sample_toggle, speaker, mute_req,
        output aud_l, aud_r, level, clip, ramp_busy
    );

endinterface

// File: rtl/audio_pdm_mod.sv
// audio_pdm_mod
// First-order PDM modulator: a 16-bit accumulator adds the level every
// cycle and the registered carry is the output bitstream, so the ones
// density equals level/65536.
// Ports:
//   clk_vga    in   clock
//   reset_wire in   asynchronous active-high reset
//   level      in   16-bit offset-binary level
//   pdm_bit    out  registered carry bit
module audio_pdm_mod
    import audio_pdm_pkg::*;
(
    input  logic                clk_vga,
    input  logic                reset_wire,
    input  logic [SAMPLE_W-1:0] level,
    output logic                pdm_bit
);

    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic                bit_q, bit_d;

    always_comb begin
        {bit_d, acc_d} = {1'b0, acc_q} + {1'b0, level};
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            acc_q <= '0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign pdm_bit = bit_q;

endmodule

// File: rtl/audio_pdm_dac.sv
// audio_pdm_dac
// Mixes OPL2, Tandy and PC-speaker audio, saturates, applies a soft
// mute/unmute volume ramp and drives a PDM bitstream on both channels.
// Ports:
//   clk_vga    in   clock, all logic on the rising edge
//   reset_wire in   asynchronous active-high reset
//   bus        slave modport of audio_pdm_dac_if (samples, toggle, speaker,
//              mute_req in; aud_l, aud_r, level, clip, ramp_busy out)
module audio_pdm_dac
    import audio_pdm_pkg::*;
#(
    parameter int OPL_SHIFT   = 1,
    parameter int TANDY_SHIFT = 6,
    parameter int SPK_SHIFT   = 13,
    parameter int RAMP_DIV    = 1024
)(
    input  logic           clk_vga,
    input  logic           reset_wire,
    audio_pdm_dac_if.slave bus
);

    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(RAMP_DIV - 1);
    localparam logic [VOL_W-1:0]   VOL_FULL      = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0]   VOL_NEAR_FULL = VOL_W'(VOL_MAX - 1);

    // Synchronizers and sample holding registers
    logic toggle_s1_q, toggle_s1_d, toggle_s2_q, toggle_s2_d, toggle_s3_q, toggle_s3_d;
    logic spk_s1_q, spk_s1_d, spk_s2_q, spk_s2_d;
    logic mute_s1_q, mute_s1_d, mute_s2_q, mute_s2_d;
    logic signed [SAMPLE_W-1:0] opl_hold_q, opl_hold_d, tandy_hold_q, tandy_hold_d;

    // Mixer / scaler / level pipeline
    logic signed [MIX_W-1:0]      mix_sum;
    logic signed [SAMPLE_W-1:0]   sat_q, sat_d;
    logic                         clip_q, clip_d;
    logic signed [SAMPLE_W+9:0]   scaled_prod;
    logic signed [SAMPLE_W-1:0]   scaled_q, scaled_d;
    logic [SAMPLE_W-1:0]          level_q, level_d;

    // Volume FSM
    vol_state_t          state_q, state_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                busy_q, busy_d;
    logic                ramp_tick;
    logic                mute_sync;

    logic                pdm_bit;

    assign mute_sync = mute_s2_q;

    always_comb begin
        toggle_s1_d  = bus.sample_toggle;
        toggle_s2_d  = toggle_s1_q;
        toggle_s3_d  = toggle_s2_q;
        spk_s1_d     = bus.speaker;
        spk_s2_d     = spk_s1_q;
        mute_s1_d    = bus.mute_req;
        mute_s2_d    = mute_s1_q;

        // The source guarantees the samples are stable while the toggle
        // is unchanged, so capturing them after the synchronized edge is safe.
        opl_hold_d   = opl_hold_q;
        tandy_hold_d = tandy_hold_q;
        if (toggle_s2_q != toggle_s3_q) begin
            opl_hold_d   = bus.opl_sample;
            tandy_hold_d = bus.tandy_sample;
        end

        mix_sum = (sext_sample(opl_hold_q) <<< OPL_SHIFT)
                + (sext_sample(tandy_hold_q) <<< TANDY_SHIFT)
                + $signed({{(MIX_W-1){1'b0}}, spk_s2_q} << SPK_SHIFT);
        sat_d   = saturate(mix_sum);
        clip_d  = mix_clipped(mix_sum);

        // vol 256 scales by exactly one; the shift floors toward -inf.
        scaled_prod = sat_q * $signed({1'b0, vol_q});
        scaled_d    = SAMPLE_W'(scaled_prod >>> 8);

        // Adding 0x8000 to a 16-bit two's complement value is an MSB flip.
        level_d = {~scaled_q[SAMPLE_W-1], scaled_q[SAMPLE_W-2:0]};
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            toggle_s1_q  <= 1'b0;
            toggle_s2_q  <= 1'b0;
            toggle_s3_q  <= 1'b0;
            spk_s1_q     <= 1'b0;
            spk_s2_q     <= 1'b0;
            mute_s1_q    <= 1'b0;
            mute_s2_q    <= 1'b0;
            opl_hold_q   <= '0;
            tandy_hold_q <= '0;
            sat_q        <= '0;
            clip_q       <= 1'b0;
            scaled_q     <= '0;
            level_q      <= LEVEL_MID;
        end else begin
            toggle_s1_q  <= toggle_s1_d;
            toggle_s2_q  <= toggle_s2_d;
            toggle_s3_q  <= toggle_s3_d;
            spk_s1_q     <= spk_s1_d;
            spk_s2_q     <= spk_s2_d;
            mute_s1_q    <= mute_s1_d;
            mute_s2_q    <= mute_s2_d;
            opl_hold_q   <= opl_hold_d;
            tandy_hold_q <= tandy_hold_d;
            sat_q        <= sat_d;
            clip_q       <= clip_d;
            scaled_q     <= scaled_d;
            level_q      <= level_d;
        end
    end

    // The prescaler defaults to zero, so it clears on every state change
    // and stays cleared outside the ramp states. Reversing direction keeps
    // the current vol, so the output never jumps.
    always_comb begin
        state_d   = state_q;
        vol_d     = vol_q;
        presc_d   = '0;
        ramp_tick = (presc_q == PRESC_LAST);
        case (state_q)
            MUTED: begin
                if (!mute_sync) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (mute_sync) begin
                    state_d = RAMP_DOWN;
                end else if (vol_q == VOL_FULL) begin
                    state_d = RUN;
                end else if (ramp_tick) begin
                    vol_d = vol_q + 1'b1;
                    if (vol_q == VOL_NEAR_FULL) state_d = RUN;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            RUN: begin
                vol_d = VOL_FULL;
                if (mute_sync) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!mute_sync) begin
                    state_d = RAMP_UP;
                end else if (vol_q == '0) begin
                    state_d = MUTED;
                end else if (ramp_tick) begin
                    vol_d = vol_q - 1'b1;
                    if (vol_q == VOL_W'(1)) state_d = MUTED;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = MUTED;
                vol_d   = '0;
            end
        endcase
        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            state_q <= MUTED;
            vol_q   <= '0;
            presc_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
        end
    end

    audio_pdm_mod u_mod (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .level      (level_q),
        .pdm_bit    (pdm_bit)
    );

    assign bus.aud_l     = pdm_bit;
    assign bus.aud_r     = pdm_bit;
    assign bus.level     = level_q;
    assign bus.clip      = clip_q;
    assign bus.ramp_busy = busy_q;

endmodule

// File: tb/tb_audio_pdm_dac.sv
// tb_audio_pdm_dac
// Directed and randomized bench for audio_pdm_dac with RAMP_DIV = 4.
// Expected levels come from an arithmetic model of the mix/clamp/scale
// rules; expected volume is derived from elapsed cycles of each ramp.
module tb_audio_pdm_dac;

    localparam int OPL_SHIFT   = 1;
    localparam int TANDY_SHIFT = 6;
    localparam int SPK_SHIFT   = 13;
    localparam int RAMP_DIV    = 4;
    localparam int RAMP_LEN    = 256 * RAMP_DIV;

    logic clk_vga    = 1'b0;
    logic reset_wire = 1'b1;
    logic tog        = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    audio_pdm_dac_if bus ();

    audio_pdm_dac #(
        .OPL_SHIFT   (OPL_SHIFT),
        .TANDY_SHIFT (TANDY_SHIFT),
        .SPK_SHIFT   (SPK_SHIFT),
        .RAMP_DIV    (RAMP_DIV)
    ) dut (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .bus        (bus)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] opl, input logic [15:0] tandy, input logic spk);
        bus.opl_sample    = opl;
        bus.tandy_sample  = tandy;
        bus.speaker       = spk;
        tog               = ~tog;
        bus.sample_toggle = tog;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk_vga);
    endtask

    function automatic int mixModel(input logic [15:0] opl, input logic [15:0] tandy, input logic spk);
        int o;
        int t;
        o = int'($signed(opl));
        t = int'($signed(tandy));
        return o * (1 << OPL_SHIFT) + t * (1 << TANDY_SHIFT) + (spk ? (1 << SPK_SHIFT) : 0);
    endfunction

    function automatic logic [15:0] levelModel(input int mix, input int vol);
        int sat;
        int scaled;
        sat    = (mix > 32767) ? 32767 : ((mix < -32768) ? -32768 : mix);
        scaled = (sat * vol) >>> 8;
        return 16'(scaled + 32768);
    endfunction

    // x = edges since the mute input changed; the FSM reacts on edge 3
    function automatic int volUp(input int x, input int v0);
        int v;
        if (x < 3) return v0;
        v = v0 + (x - 3) / RAMP_DIV;
        return (v > 256) ? 256 : v;
    endfunction

    function automatic int volDown(input int x, input int v0);
        int v;
        if (x < 3) return v0;
        v = v0 - (x - 3) / RAMP_DIV;
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        logic [15:0] ro, rt;
        logic        rs;
        int          m;

        bus.opl_sample    = '0;
        bus.tandy_sample  = '0;
        bus.sample_toggle = 1'b0;
        bus.speaker       = 1'b0;
        bus.mute_req      = 1'b1;

        // Reset state
        waitEdges(3);
        checkOutput("reset_level", 32'(bus.level), 32'h8000);
        checkOutput("reset_aud_l", 32'(bus.aud_l), 0);
        checkOutput("reset_aud_r", 32'(bus.aud_r), 0);
        checkOutput("reset_clip", 32'(bus.clip), 0);
        checkOutput("reset_busy", 32'(bus.ramp_busy), 0);
        reset_wire = 1'b0;

        // Muted midpoint: PDM alternates 0,1,0,1
        for (int i = 1; i <= 8; i++) begin
            waitEdges(1);
            checkOutput("mid_aud_l", 32'(bus.aud_l), (i % 2 == 0) ? 1 : 0);
            checkOutput("mid_aud_r", 32'(bus.aud_r), (i % 2 == 0) ? 1 : 0);
            checkOutput("mid_level", 32'(bus.level), 32'h8000);
        end

        // Sample loaded while muted has no effect on level
        applyStimulus(16'h1000, 16'h0000, 1'b0);
        waitEdges(8);
        checkOutput("muted_level", 32'(bus.level), 32'h8000);
        checkOutput("muted_busy", 32'(bus.ramp_busy), 0);

        // Unmute: full ramp up
        bus.mute_req = 1'b0;
        for (int e = 1; e <= RAMP_LEN + 6; e++) begin
            waitEdges(1);
            checkOutput("ramp_up_level", 32'(bus.level), 32'(levelModel(mixModel(16'h1000, 16'h0, 1'b0), volUp(e - 2, 0))));
            checkOutput("ramp_up_busy", 32'(bus.ramp_busy), (e >= 3 && e < 3 + RAMP_LEN) ? 1 : 0);
        end
        checkOutput("run_level_a000", 32'(bus.level), 32'hA000);
        checkOutput("run_busy_low", 32'(bus.ramp_busy), 0);

        // Randomized samples at unity volume
        for (int i = 0; i < 24; i++) begin
            ro = 16'($urandom);
            rt = (i % 2 == 1) ? 16'($urandom) : 16'($urandom_range(1023, 0) - 512);
            rs = 1'($urandom_range(1, 0));
            applyStimulus(ro, rt, rs);
            waitEdges(6);
            m = mixModel(ro, rt, rs);
            checkOutput("rand_level", 32'(bus.level), 32'(levelModel(m, 256)));
            checkOutput("rand_clip", 32'(bus.clip), (m > 32767 || m < -32768) ? 1 : 0);
        end

        // Positive and negative saturation
        applyStimulus(16'h7FFF, 16'h0100, 1'b0);
        waitEdges(4);
        checkOutput("clip_pos_pulse", 32'(bus.clip), 1);
        waitEdges(2);
        checkOutput("clip_pos_level", 32'(bus.level), 32'hFFFF);
        applyStimulus(16'h8000, 16'hFF00, 1'b0);
        waitEdges(6);
        checkOutput("clip_neg_level", 32'(bus.level), 32'h0000);
        checkOutput("clip_neg_clip", 32'(bus.clip), 1);
        for (int i = 0; i < 16; i++) begin
            waitEdges(1);
            checkOutput("zero_level_aud", 32'(bus.aud_l), 0);
        end

        // Toggle-to-level latency: 6th edge, not the 5th
        applyStimulus(16'h0400, 16'h0000, 1'b0);
        waitEdges(5);
        checkOutput("latency_edge5", 32'(bus.level), 32'h0000);
        waitEdges(1);
        checkOutput("latency_edge6", 32'(bus.level), 32'h8800);

        // Mute from RUN: full ramp down
        bus.mute_req = 1'b1;
        for (int e = 1; e <= RAMP_LEN + 6; e++) begin
            waitEdges(1);
            checkOutput("ramp_down_level", 32'(bus.level), 32'(levelModel(mixModel(16'h0400, 16'h0, 1'b0), volDown(e - 2, 256))));
            checkOutput("ramp_down_busy", 32'(bus.ramp_busy), (e >= 3 && e < 3 + RAMP_LEN) ? 1 : 0);
        end

        // Ramp up to vol 100, then reverse
        bus.mute_req = 1'b0;
        for (int e = 1; e <= 3 + 100 * RAMP_DIV; e++) begin
            waitEdges(1);
            checkOutput("rev_up_level", 32'(bus.level), 32'(levelModel(mixModel(16'h0400, 16'h0, 1'b0), volUp(e - 2, 0))));
            checkOutput("rev_up_busy", 32'(bus.ramp_busy), (e >= 3) ? 1 : 0);
        end
        bus.mute_req = 1'b1;
        for (int f = 1; f <= 6 + 100 * RAMP_DIV; f++) begin
            waitEdges(1);
            if (f >= 2) begin
                checkOutput("rev_down_level", 32'(bus.level), 32'(levelModel(mixModel(16'h0400, 16'h0, 1'b0), volDown(f - 2, 100))));
            end
            if (f == 9) begin
                checkOutput("rev_vol99", 32'(bus.level), 32'h8318);
            end
            checkOutput("rev_down_busy", 32'(bus.ramp_busy), (f < 3 + 100 * RAMP_DIV) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a ramp down
        if (tog) begin
            applyStimulus(16'h0400, 16'h0000, 1'b0);
            waitEdges(8);
        end
        bus.mute_req = 1'b0;
        waitEdges(200);
        bus.mute_req = 1'b1;
        waitEdges(40);
        checkOutput("pre_reset_busy", 32'(bus.ramp_busy), 1);
        #2;
        reset_wire = 1'b1;
        #1;
        checkOutput("async_reset_level", 32'(bus.level), 32'h8000);
        checkOutput("async_reset_aud_l", 32'(bus.aud_l), 0);
        checkOutput("async_reset_aud_r", 32'(bus.aud_r), 0);
        checkOutput("async_reset_busy", 32'(bus.ramp_busy), 0);
        checkOutput("async_reset_clip", 32'(bus.clip), 0);
        waitEdges(3);
        reset_wire   = 1'b0;
        bus.mute_req = 1'b0;

        // Restart from MUTED with cleared holding registers: level stays at
        // midpoint for the whole ramp since no new sample was toggled in.
        for (int e = 1; e <= RAMP_LEN + 16; e++) begin
            waitEdges(1);
            checkOutput("restart_level", 32'(bus.level), 32'h8000);
            checkOutput("restart_busy", 32'(bus.ramp_busy), (e >= 1 && e < 1 + RAMP_LEN) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_pdm_dac.md
AUDIO_PDM_DAC -- requirements
Module: audio_pdm_dac

Interface
REQ-001 Parameter OPL_SHIFT, default 1, left shift applied to the OPL2 sample before mixing.
REQ-002 Parameter TANDY_SHIFT, default 6, left shift applied to the Tandy sample before mixing.
REQ-003 Parameter SPK_SHIFT, default 13, PC speaker contribution is 2^SPK_SHIFT when the bit is high.
REQ-004 Parameter RAMP_DIV, default 1024, clk_vga cycles per volume ramp step.
REQ-005 clk_vga  in  1  clock, 28.636 MHz, all logic on its rising edge.
REQ-006 reset_wire  in  1  reset, asynchronous, active-high.
REQ-007 opl_sample  in  16  signed OPL2 sample, clk_chipset domain, stable while sample_toggle is unchanged.
REQ-008 tandy_sample  in  16  signed Tandy sound sample, same rules as opl_sample.
REQ-009 sample_toggle  in  1  inverts once per new sample pair, clk_chipset domain.
REQ-010 speaker  in  1  PC speaker bit, asynchronous.
REQ-011 mute_req  in  1  asynchronous soft-mute request, high = mute.
REQ-012 aud_l, aud_r  out  1 each  identical PDM audio bitstreams.
REQ-013 level  out  16  offset-binary value currently fed to the modulator.
REQ-014 clip  out  1  one-cycle pulse, mixer saturated this cycle.
REQ-015 ramp_busy  out  1  high in RAMP_UP or RAMP_DOWN.

Function
REQ-016 sample_toggle, speaker and mute_req each pass through a 2-flop synchronizer; sample_toggle has an extra flop for edge detect.
REQ-017 On a detected toggle edge, opl_sample and tandy_sample are captured into holding registers on the next edge; holding registers otherwise keep their value.
REQ-018 Mixer, registered every cycle: 24-bit signed sum of sign-extended (opl<<OPL_SHIFT) + (tandy<<TANDY_SHIFT) + (speaker_sync ? 2^SPK_SHIFT : 0).
REQ-019 Saturation: sum clamps to [-32768, 32767]; clip pulses high in the same cycle the clamped value is registered.
REQ-020 Scaling, registered: scaled = (sat * vol) >>> 8, arithmetic shift, vol in 0..256; vol 256 is exact unity.
REQ-021 level = scaled + 0x8000 (MSB invert), registered; vol 0 gives level 0x8000.
REQ-022 Latency: a toggle transition shows up in level after the 6th clk_vga rising edge (sampling edge counts as 1): 2 sync + detect + capture + mix + scale/level.
REQ-023 Volume FSM states: MUTED (vol 0), RAMP_UP, RUN (vol 256), RAMP_DOWN.
REQ-024 A prescaler counts 0..RAMP_DIV-1 and issues a tick at wrap; it runs only in the RAMP states and clears on any state change.
REQ-025 MUTED→RAMP_UP when mute_sync=0; RAMP_UP: vol+1 per tick, at 256 →RUN; RUN→RAMP_DOWN when mute_sync=1; RAMP_DOWN: vol-1 per tick, at 0 →MUTED.
REQ-026 mute_sync=1 in RAMP_UP → RAMP_DOWN from the current vol; mute_sync=0 in RAMP_DOWN → RAMP_UP from the current vol; no vol jump.
REQ-027 Modulator: 16-bit accumulator, {carry,acc} <= acc + level every cycle; aud_l = aud_r = registered carry.
REQ-028 Duty cycle of the PDM output = level/65536 exactly over any 65536-cycle window with constant level.

Reset
REQ-029 On reset_wire: all synchronizers and holding registers 0, mix/scaled 0, level 0x8000, acc 0, aud_l/aud_r 0, clip 0, state MUTED, vol 0, prescaler 0, ramp_busy 0.
REQ-030 A reset asserted mid-ramp or mid-sample takes effect immediately (asynchronously); after release the module restarts from MUTED with no residual state.

Structure
REQ-031 Shared package audio_pdm_pkg holds the state enum, VOL_MAX=256, the 0x8000 midpoint constant and the sample widths.
REQ-032 The accumulator/carry modulator is a sub-module, audio_pdm_mod (level in, bit out, clk_vga, reset_wire).

Verification
REQ-033 Reset, mute_req=1, samples 0 → level stays 0x8000, aud_l alternates 0,1,0,1 starting from 0 after the first edge.
REQ-034 mute_req=0, RAMP_DIV=4 → vol reaches 256 after 1024 cycles of RAMP_UP, then RUN, ramp_busy falls; opl=0x1000 gives level 0xA000.
REQ-035 In RUN: opl=0x7FFF, tandy=0x0100 → clip pulses, level 0xFFFF; opl=0x8000, tandy=0xFF00 → clip, level 0x0000, aud_l constant 0.
REQ-036 In RUN: flip sample_toggle with opl=0x0400 → level becomes 0x8800 on exactly the 6th edge, not the 5th.
REQ-037 RAMP_DIV=4, mute_req=1 at vol=100 during RAMP_UP → RAMP_DOWN, vol 99 after 4 cycles, MUTED at vol 0 with no jump.
REQ-038 Assert reset_wire mid-RAMP_DOWN → same cycle state MUTED, level 0x8000, aud_l 0.
